// File: rtl/subtrator_8.sv
// ============================================================================
//  Module   : subtrator_8
//  Function : Registered WIDTH-bit unsigned subtractor (ripple-borrow) with
//             zero, borrow and signed-overflow flags; one-cycle latency.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module subtrator_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   s,
    output logic             out_valid,
    output logic             zero,
    output logic             borrow,
    output logic             ovf_signed
);

    logic [WIDTH-1:0] w_diff;
    logic             w_bout;
    logic             w_zero;
    logic             w_ovf;

    logic [WIDTH:0]   r_s;
    logic             r_valid;
    logic             r_zero;
    logic             r_borrow;
    logic             r_ovf;

    // Ripple chain of full-subtractor cells; the running borrow is a loop
    // variable so the chain stays a single combinational cone.
    always_comb begin
        logic w_bin;
        w_bin  = 1'b0;
        w_diff = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_diff[i] = a[i] ^ b[i] ^ w_bin;
            w_bin     = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_bin);
        end
        w_bout = w_bin;
    end

    assign w_zero = (a == b);
    assign w_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

    // Result and flags only move on an accepted operand pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s      <= '0;
            r_valid  <= 1'b0;
            r_zero   <= 1'b0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_s      <= {w_bout, w_diff};
                r_zero   <= w_zero;
                r_borrow <= w_bout;
                r_ovf    <= w_ovf;
            end
        end
    end

    assign s          = r_s;
    assign out_valid  = r_valid;
    assign zero       = r_zero;
    assign borrow     = r_borrow;
    assign ovf_signed = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_subtrator_8.sv
// ============================================================================
//  Module   : tb_subtrator_8
//  Function : Self-checking bench for subtrator_8 (directed table, hold,
//             reset corners and exhaustive operand sweep).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_subtrator_8;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] s;
    logic       out_valid;
    logic       zero;
    logic       borrow;
    logic       ovf_signed;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] s;
        logic       zero;
        logic       borrow;
        logic       ovf;
    } vec_t;

    vec_t vecs [8];

    subtrator_8 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .s          (s),
        .out_valid  (out_valid),
        .zero       (zero),
        .borrow     (borrow),
        .ovf_signed (ovf_signed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [8:0] es, input logic ev,
                             input logic ez, input logic eb, input logic eo);
        check({tag, ".s"},          s,                 es);
        check({tag, ".out_valid"},  {8'd0, out_valid}, {8'd0, ev});
        check({tag, ".zero"},       {8'd0, zero},      {8'd0, ez});
        check({tag, ".borrow"},     {8'd0, borrow},    {8'd0, eb});
        check({tag, ".ovf_signed"}, {8'd0, ovf_signed},{8'd0, eo});
    endtask

    initial begin
        logic [8:0] m_s;
        int         m_sd;
        logic       m_ovf;

        checks = 0;
        errors = 0;

        vecs[0] = '{a: 8'd20,  b: 8'd10,  s: 9'h00A, zero: 1'b0, borrow: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'd2,   b: 8'd1,   s: 9'h001, zero: 1'b0, borrow: 1'b0, ovf: 1'b0};
        vecs[2] = '{a: 8'd0,   b: 8'd0,   s: 9'h000, zero: 1'b1, borrow: 1'b0, ovf: 1'b0};
        vecs[3] = '{a: 8'd100, b: 8'd200, s: 9'h19C, zero: 1'b0, borrow: 1'b1, ovf: 1'b1};
        vecs[4] = '{a: 8'd0,   b: 8'd255, s: 9'h101, zero: 1'b0, borrow: 1'b1, ovf: 1'b0};
        vecs[5] = '{a: 8'd255, b: 8'd0,   s: 9'h0FF, zero: 1'b0, borrow: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 8'd128, b: 8'd1,   s: 9'h07F, zero: 1'b0, borrow: 1'b0, ovf: 1'b1};
        vecs[7] = '{a: 8'd50,  b: 8'd20,  s: 9'h01E, zero: 1'b0, borrow: 1'b0, ovf: 1'b0};

        // Reset held with valid operands present
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 8'd20;
        b        = 8'd10;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_all("reset", 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Back-to-back directed stream
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a        = vecs[i].a;
            b        = vecs[i].b;
            in_valid = 1'b1;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].s, 1'b1,
                      vecs[i].zero, vecs[i].borrow, vecs[i].ovf);
        end

        // Hold after 50/20 with junk operands and no valid
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            tick();
            check_all("hold", 9'h01E, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Reset coinciding with a valid pair discards it
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 8'd7;
        b        = 8'd9;
        tick();
        check_all("midrst", 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check_all("postrst", 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Exhaustive sweep against an arithmetic reference
        in_valid = 1'b1;
        for (int ia = 0; ia < 256; ia++) begin
            for (int ib = 0; ib < 256; ib++) begin
                a = 8'(ia);
                b = 8'(ib);
                tick();
                m_s   = {1'b0, 8'(ia)} - {1'b0, 8'(ib)};
                m_sd  = int'($signed(8'(ia))) - int'($signed(8'(ib)));
                m_ovf = (m_sd > 127) || (m_sd < -128);
                check_all("sweep", m_s, 1'b1, (ia == ib), (ia < ib), m_ovf);
            end
        end
        in_valid = 1'b0;
        tick();
        check("sweep_end.out_valid", {8'd0, out_valid}, 9'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
